// File: rtl/ray_scan_scheduler.sv
// Frame sequencer for the view-ray generator: latches camera config, walks the canvas
// row-major, waits out the generator latency and hands each ray downstream on valid/ready.
module ray_scan_scheduler #(
    parameter int unsigned COLS    = 128,
    parameter int unsigned ROWS    = 64,
    parameter int unsigned RAY_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [30:0] cfg_normal,
    input  logic [7:0]  cfg_dist,
    output logic [30:0] view_normal,
    output logic [7:0]  view_dist,
    output logic [12:0] view_loc,
    input  logic [30:0] view_ray_in,
    output logic [30:0] ray_out,
    output logic [12:0] ray_loc,
    output logic        ray_valid,
    input  logic        ray_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [6:0] ColLast = 7'(COLS - 1);
    localparam logic [5:0] RowLast = 6'(ROWS - 1);
    localparam logic [3:0] LatInit = 4'(RAY_LAT);

    typedef enum logic [1:0] {StIdle, StWait, StValid} state_t;

    state_t     state;
    logic [3:0] lat_cnt;
    logic [6:0] col;
    logic [5:0] row;
    logic       last_pixel;

    assign view_loc   = {col, row};
    assign last_pixel = (col == ColLast) && (row == RowLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            lat_cnt     <= 4'd0;
            col         <= 7'd0;
            row         <= 6'd0;
            view_normal <= 31'd0;
            view_dist   <= 8'd0;
            ray_out     <= '1;
            ray_loc     <= 13'd0;
            ray_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Abort beats everything, including a handshake in the same cycle.
            if (abort && state != StIdle) begin
                state     <= StIdle;
                ray_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        // A start coinciding with the frame_done pulse waits one cycle.
                        if (start && !frame_done) begin
                            view_normal <= cfg_normal;
                            view_dist   <= cfg_dist;
                            col         <= 7'd0;
                            row         <= 6'd0;
                            lat_cnt     <= LatInit;
                            busy        <= 1'b1;
                            state       <= StWait;
                        end
                    end
                    StWait: begin
                        lat_cnt <= lat_cnt - 4'd1;
                        if (lat_cnt == 4'd1) begin
                            ray_out   <= view_ray_in;
                            ray_loc   <= {col, row};
                            ray_valid <= 1'b1;
                            state     <= StValid;
                        end
                    end
                    StValid: begin
                        if (ray_ready) begin
                            ray_valid <= 1'b0;
                            if (last_pixel) begin
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                state      <= StIdle;
                            end else begin
                                if (col == ColLast) begin
                                    col <= 7'd0;
                                    row <= row + 6'd1;
                                end else begin
                                    col <= col + 7'd1;
                                end
                                lat_cnt <= LatInit;
                                state   <= StWait;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ray_scan_scheduler.sv
// Scoreboard bench for ray_scan_scheduler: a behavioural ray generator feeds the DUT and the
// expected ray stream per frame is queued up front and popped on every downstream handshake.
module tb_ray_scan_scheduler;

    localparam int unsigned COLS    = 128;
    localparam int unsigned ROWS    = 64;
    localparam int unsigned RAY_LAT = 2;
    localparam int          NPIX    = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst, start, abort, ray_ready;
    logic [30:0] cfg_normal, view_normal, view_ray_in, ray_out;
    logic [7:0]  cfg_dist, view_dist;
    logic [12:0] view_loc, ray_loc;
    logic        ray_valid, busy, frame_done;

    ray_scan_scheduler #(.COLS(COLS), .ROWS(ROWS), .RAY_LAT(RAY_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_normal(cfg_normal), .cfg_dist(cfg_dist),
        .view_normal(view_normal), .view_dist(view_dist), .view_loc(view_loc),
        .view_ray_in(view_ray_in), .ray_out(ray_out), .ray_loc(ray_loc),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] ray_model(input logic [12:0] loc, input logic [30:0] n,
                                              input logic [7:0] d);
        logic [30:0] l;
        l = {18'd0, loc};
        return (n ^ (l * 31'd40503)) + ({23'd0, d} * 31'd977);
    endfunction

    // Generator stand-in: result settles one cycle after view_loc moves, inside RAY_LAT=2.
    initial view_ray_in = 31'd0;
    always @(posedge clk) view_ray_in <= ray_model(view_loc, view_normal, view_dist);

    typedef struct packed {
        logic [12:0] loc;
        logic [30:0] ray;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, start_cyc = 0, first_valid = -1, hs_count = 0, fd_count = 0;
    bit          first_seen = 1'b0;
    logic [30:0] exp_normal = 31'd0;
    logic [7:0]  exp_dist = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [30:0] n, input logic [7:0] d);
        logic [12:0] loc;
        sb.delete();
        for (int idx = 0; idx < NPIX; idx++) begin
            loc = {7'(idx % COLS), 6'(idx / COLS)};
            sb.push_back({loc, ray_model(loc, n, d)});
        end
    endtask

    // Monitor: config hold while busy, ray stream vs scoreboard, frame_done bookkeeping.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy) begin
                    check("view_normal hold", view_normal, exp_normal);
                    check("view_dist hold", view_dist, exp_dist);
                end
                if (ray_valid && !first_seen) begin
                    first_seen  = 1'b1;
                    first_valid = cyc - start_cyc;
                end
                if (ray_valid && ray_ready) begin
                    hs_count++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected ray: got loc %0h, expected none", ray_loc);
                    end else begin
                        e = sb.pop_front();
                        check("ray_loc", ray_loc, e.loc);
                        check("ray_out", ray_out, e.ray);
                    end
                end
                if (frame_done) fd_count++;
            end
        end
    end

    task automatic start_frame(input logic [30:0] n, input logic [7:0] d);
        @(posedge clk); #1;
        cfg_normal = n; cfg_dist = d; exp_normal = n; exp_dist = d;
        push_frame(n, d);
        start = 1'b1; start_cyc = cyc; first_seen = 1'b0; hs_count = 0; fd_count = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        finish_run();
    end

    initial begin
        logic [30:0] nb, nc;
        int          t, hcyc;
        bit          aborted, done;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ray_ready = 1'b0;
        cfg_normal = 31'd0; cfg_dist = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        repeat (20) begin
            @(negedge clk);
            check("idle ray_out", ray_out, 31'h7FFFFFFF);
            check("idle ray_valid", ray_valid, 0);
            check("idle busy", busy, 0);
            check("idle view_loc", view_loc, 0);
        end

        // Frame 1: ready high, cfg changed and start pulsed mid-frame.
        ray_ready = 1'b1;
        start_frame(31'h2345_6789, 8'd40);
        repeat (1000) @(posedge clk);
        #1 cfg_normal = 31'h5A5A_1234; cfg_dist = 8'd99; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 0; done = 1'b0;
        while (!done && t < 30000) begin
            @(posedge clk); #1;
            t++;
            done = frame_done;
        end
        check("frame1 frame_done seen", done, 1);
        check("frame1 first valid cycle", first_valid, RAY_LAT + 1);
        check("frame1 frame_done cycle", cyc - start_cyc, 24577);
        check("frame1 ray count", hs_count, NPIX);
        check("frame1 leftover rays", sb.size(), 0);

        // Start raised in the frame_done cycle must wait for the next cycle.
        nb = 31'h0F0F_3C3C;
        cfg_normal = nb; cfg_dist = 8'd7; exp_normal = nb; exp_dist = 8'd7;
        start = 1'b1;
        @(posedge clk); #1;
        check("start during frame_done ignored", busy, 0);
        check("frame_done single pulse", frame_done, 0);
        check("frame1 frame_done count", fd_count, 1);
        push_frame(nb, 8'd7);
        start_cyc = cyc; first_seen = 1'b0; hs_count = 0; fd_count = 0;
        @(posedge clk); #1 start = 1'b0;
        check("frame2 busy", busy, 1);
        check("frame2 view_normal", view_normal, nb);
        check("frame2 view_dist", view_dist, 8'd7);
        check("frame2 view_loc", view_loc, 0);

        // Frame 2: random ready, stall on ray 5, abort with handshake at {10,3}.
        t = 0; aborted = 1'b0;
        while (!aborted && t < 20000) begin
            t++;
            if (ray_valid && hs_count == 5) begin
                ray_ready = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                    check("stall ray_valid", ray_valid, 1);
                    check("stall ray_loc", ray_loc, {7'd5, 6'd0});
                    check("stall view_loc", view_loc, {7'd5, 6'd0});
                    check("stall ray_out", ray_out, ray_model({7'd5, 6'd0}, nb, 8'd7));
                end
                ray_ready = 1'b1; hcyc = cyc;
                @(posedge clk); #1 ray_ready = 1'b0;
                for (int k = 0; k < 20 && !ray_valid; k++) begin
                    @(posedge clk); #1;
                end
                check("post-stall latency", cyc - hcyc, RAY_LAT + 1);
            end else if (ray_valid && ray_loc == {7'd10, 6'd3}) begin
                ray_ready = 1'b1; abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; ray_ready = 1'b0;
                check("abort busy", busy, 0);
                check("abort ray_valid", ray_valid, 0);
                check("abort frame_done", frame_done, 0);
                check("abort view_loc kept", view_loc, {7'd10, 6'd3});
                check("abort view_normal kept", view_normal, nb);
                aborted = 1'b1;
            end else begin
                ray_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        check("abort reached", aborted, 1);
        check("abort accepted rays", hs_count, 395);
        check("abort remaining expected", sb.size(), NPIX - 395);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle abort busy", busy, 0);
        check("idle abort view_loc", view_loc, {7'd10, 6'd3});
        check("no frame_done after abort", fd_count, 0);

        // Frame 3: restart from 0, start while busy, async reset at pixel 100.
        nc = 31'h7123_4567;
        ray_ready = 1'b1;
        start_frame(nc, 8'd200);
        check("frame3 restart view_loc", view_loc, 0);
        check("frame3 busy", busy, 1);
        t = 0;
        while (view_loc != {7'd100, 6'd0} && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("frame3 reached pixel 100", view_loc, {7'd100, 6'd0});
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start while busy view_loc", view_loc, {7'd100, 6'd0});
        check("start while busy busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("rst ray_out", ray_out, 31'h7FFFFFFF);
        check("rst ray_valid", ray_valid, 0);
        check("rst busy", busy, 0);
        check("rst view_loc", view_loc, 0);
        check("rst ray_loc", ray_loc, 0);
        check("rst view_normal", view_normal, 0);
        check("rst view_dist", view_dist, 0);
        check("rst frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        repeat (5) begin
            @(negedge clk);
            check("post-rst busy", busy, 0);
            check("post-rst ray_valid", ray_valid, 0);
        end
        finish_run();
    end

endmodule
